mem_wb_stage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register for the pipelined MIPS core. It consumes the EX/MEM register outputs (ALU result, store data, destination register, control bits) and drives a request/acknowledge data-memory bus. It loads the MEM/WB register and produces `WB_wd`, the write-back value that also feeds the EX-stage forwarding mux. It stalls upstream stages while a load or store waits on memory, and flags misaligned or timed-out accesses.

---
 rtl/mips_pkg.sv | 13 +
 rtl/mem_wb_stage_if.sv | 21 ++
 rtl/mux2.sv | 13 +
 rtl/mem_wb_stage.sv | 122 ++++++++++++
 tb/tb_mem_wb_stage.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and widths for the pipelined MIPS core.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  // Data-memory access FSM.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Request/acknowledge data-memory bus between the MEM stage and memory.
interface mem_wb_stage_if;

  logic                       req;
  logic                       we;
  logic [mips_pkg::WORD_W-1:0] addr;
  logic [mips_pkg::WORD_W-1:0] wdata;
  logic                       ack;
  logic [mips_pkg::WORD_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mux2.sv
// Generic two-input multiplexer: y = sel ? b : a.
module mux2 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: issues data-memory requests,
// stalls upstream while an access is outstanding, and produces WB_wd.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemtoReg,
  input  logic [WORD_W-1:0] MEM_ALUOut,
  input  logic [WORD_W-1:0] MEM_rd2,
  input  logic [REG_W-1:0]  MEM_RegRd,
  input  logic              err_clr,
  mem_wb_stage_if.master    dmem,
  output logic              mem_stall,
  output logic              WB_RegWrite,
  output logic [REG_W-1:0]  WB_RegRd,
  output logic [WORD_W-1:0] WB_wd,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [WORD_W-1:0] wd_next;

  logic mem_op, aligned, in_idle, in_wait, timeout;
  logic start, misalign, abort;

  assign mem_op   = MEM_MemRead | MEM_MemWrite;
  assign aligned  = (MEM_ALUOut[1:0] == 2'b00);
  assign in_idle  = (state == S_IDLE);
  assign in_wait  = (state == S_WAIT);
  assign timeout  = in_wait & (wait_cnt == CNT_LAST);

  assign start    = in_idle & mem_op & aligned;
  assign misalign = in_idle & mem_op & ~aligned;
  // An ack arriving in the last allowed cycle still completes the access.
  assign abort    = timeout & ~dmem.ack;

  assign mem_stall = start | (in_wait & ~dmem.ack & ~timeout);

  // Write-back select: memory data for loads, ALU result otherwise.
  mux2 #(.W(WORD_W)) u_wd_mux (
    .sel (MEM_MemtoReg),
    .a   (MEM_ALUOut),
    .b   (dmem.rdata),
    .y   (wd_next)
  );

  // Access FSM, wait counter and registered bus request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: bus outputs reset asynchronously so a reset mid-access withdraws the request at once.
      state      <= S_IDLE;
      wait_cnt   <= '0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.wdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_WAIT;
            wait_cnt   <= '0;
            dmem.req   <= 1'b1;
            dmem.we    <= MEM_MemWrite & ~MEM_MemRead;
            dmem.addr  <= MEM_ALUOut;
            dmem.wdata <= MEM_rd2;
          end
        end
        S_WAIT: begin
          if (dmem.ack || timeout) begin
            state    <= S_IDLE;
            dmem.req <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register: advances whenever the stage is not stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WB_RegWrite <= 1'b0;
      WB_RegRd    <= '0;
      WB_wd       <= '0;
    end else if (!mem_stall) begin
      WB_RegWrite <= MEM_RegWrite & ~misalign & ~abort;
      WB_RegRd    <= MEM_RegRd;
      WB_wd       <= wd_next;
    end else begin
      WB_RegWrite <= 1'b0;
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      if (misalign)     misalign_err <= 1'b1;
      else if (err_clr) misalign_err <= 1'b0;
      if (abort)        bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed table, reset corner case,
// and randomized operations against a transaction-level reference model.
module tb_mem_wb_stage;
  import mips_pkg::*;

  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_MemtoReg;
  logic [WORD_W-1:0] MEM_ALUOut, MEM_rd2;
  logic [REG_W-1:0]  MEM_RegRd;
  logic              err_clr;
  logic              mem_stall, WB_RegWrite, misalign_err, bus_err;
  logic [REG_W-1:0]  WB_RegRd;
  logic [WORD_W-1:0] WB_wd;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .MEM_MemRead  (MEM_MemRead),
    .MEM_MemWrite (MEM_MemWrite),
    .MEM_RegWrite (MEM_RegWrite),
    .MEM_MemtoReg (MEM_MemtoReg),
    .MEM_ALUOut   (MEM_ALUOut),
    .MEM_rd2      (MEM_rd2),
    .MEM_RegRd    (MEM_RegRd),
    .err_clr      (err_clr),
    .dmem         (bus),
    .mem_stall    (mem_stall),
    .WB_RegWrite  (WB_RegWrite),
    .WB_RegRd     (WB_RegRd),
    .WB_wd        (WB_wd),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  // One pipeline operation as presented by the EX/MEM register, plus the
  // memory's response: ack 'delay' cycles after req rises (-1 = never).
  typedef struct {
    logic        rd, wr, rw, m2r;
    logic [31:0] alu, rd2;
    logic [4:0]  regrd;
    int          delay;
    logic [31:0] rdata;
    logic        clr;
  } op_t;

  // What one operation looks like from outside the stage.
  typedef struct {
    int          stall, reqc, extra_writes;
    logic        we;
    logic [31:0] addr, wdata;
    logic        stable;
    logic        wb_rw;
    logic [31:0] wd;
    logic        wd_chk;
    logic [4:0]  regrd;
    logic        mis, bus;
  } obs_t;

  typedef struct {
    op_t  op;
    obs_t exp;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  logic exp_mis = 1'b0;
  logic exp_bus = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic op_t mk_op(logic rd, logic wr, logic rw, logic m2r, logic [31:0] alu,
                                logic [31:0] rd2, logic [4:0] regrd, int delay,
                                logic [31:0] rdata, logic clr);
    op_t o;
    o.rd = rd; o.wr = wr; o.rw = rw; o.m2r = m2r; o.alu = alu; o.rd2 = rd2;
    o.regrd = regrd; o.delay = delay; o.rdata = rdata; o.clr = clr;
    return o;
  endfunction

  function automatic obs_t mk_exp(int stall, int reqc, logic we, logic [31:0] addr,
                                  logic [31:0] wdata, logic wb_rw, logic [31:0] wd,
                                  logic [4:0] regrd, logic mis, logic bus_e);
    obs_t e;
    e.stall = stall; e.reqc = reqc; e.extra_writes = 0; e.we = we; e.addr = addr;
    e.wdata = wdata; e.stable = 1'b1; e.wb_rw = wb_rw; e.wd = wd; e.wd_chk = 1'b1;
    e.regrd = regrd; e.mis = mis; e.bus = bus_e;
    return e;
  endfunction

  // Reference model: outcome of one whole operation from the stage's rules.
  function automatic obs_t model(op_t op, logic mis_old, logic bus_old);
    obs_t e;
    logic set_mis, set_bus, mem, ok;
    e = '{default: 0};
    e.stable = 1'b1;
    e.regrd  = op.regrd;
    set_mis  = 1'b0;
    set_bus  = 1'b0;
    ok       = 1'b0;
    mem      = op.rd | op.wr;
    if (!mem) begin
      e.wb_rw = op.rw;
    end else if (op.alu[1:0] != 2'b00) begin
      set_mis = 1'b1;
    end else begin
      e.we    = op.wr & ~op.rd;
      e.addr  = op.alu;
      e.wdata = op.rd2;
      if (op.delay >= 0 && op.delay < TIMEOUT) begin
        e.stall = op.delay + 1;
        e.reqc  = op.delay + 1;
        e.wb_rw = op.rw;
        ok      = 1'b1;
      end else begin
        e.stall = TIMEOUT;
        e.reqc  = TIMEOUT;
        set_bus = 1'b1;
      end
    end
    e.wd     = op.m2r ? op.rdata : op.alu;
    e.wd_chk = ~op.m2r | ok;
    e.mis    = set_mis | (~op.clr & mis_old);
    e.bus    = set_bus | (~op.clr & bus_old);
    return e;
  endfunction

  // Present one op, play the memory side, and collect what the stage did.
  task automatic run_op(input op_t op, input bit noise, output obs_t o);
    logic st;
    int   seen;
    bit   first;
    MEM_MemRead  = op.rd;
    MEM_MemWrite = op.wr;
    MEM_RegWrite = op.rw;
    MEM_MemtoReg = op.m2r;
    MEM_ALUOut   = op.alu;
    MEM_rd2      = op.rd2;
    MEM_RegRd    = op.regrd;
    err_clr      = op.clr;
    bus.rdata    = op.rdata;
    o        = '{default: 0};
    o.stable = 1'b1;
    seen     = 0;
    first    = 1'b1;
    st       = 1'b1;
    for (int k = 0; k < 40 && st; k++) begin
      if (bus.req) bus.ack = (seen == op.delay);
      else         bus.ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      st = mem_stall;
      if (k > 0 && WB_RegWrite) o.extra_writes++;
      if (bus.req) begin
        if (first) begin
          o.we = bus.we; o.addr = bus.addr; o.wdata = bus.wdata;
          first = 1'b0;
        end else if (bus.we !== o.we || bus.addr !== o.addr || bus.wdata !== o.wdata) begin
          o.stable = 1'b0;
        end
        o.reqc++;
        seen++;
      end
      if (st) o.stall++;
      @(posedge clk);
      #1;
    end
    bus.ack  = 1'b0;
    o.wb_rw  = WB_RegWrite;
    o.wd     = WB_wd;
    o.regrd  = WB_RegRd;
    o.mis    = misalign_err;
    o.bus    = bus_err;
  endtask

  task automatic compare(input string tag, input obs_t g, input obs_t e);
    check({tag, " stall_cycles"}, 32'(g.stall), 32'(e.stall));
    check({tag, " req_cycles"}, 32'(g.reqc), 32'(e.reqc));
    if (e.reqc > 0) begin
      check({tag, " dmem_we"}, 32'(g.we), 32'(e.we));
      check({tag, " dmem_addr"}, g.addr, e.addr);
      check({tag, " dmem_wdata"}, g.wdata, e.wdata);
      check({tag, " bus_stable"}, 32'(g.stable), 32'(e.stable));
    end
    check({tag, " dup_writes"}, 32'(g.extra_writes), 32'(e.extra_writes));
    check({tag, " WB_RegWrite"}, 32'(g.wb_rw), 32'(e.wb_rw));
    check({tag, " WB_RegRd"}, 32'(g.regrd), 32'(e.regrd));
    if (e.wd_chk) check({tag, " WB_wd"}, g.wd, e.wd);
    check({tag, " misalign_err"}, 32'(g.mis), 32'(e.mis));
    check({tag, " bus_err"}, 32'(g.bus), 32'(e.bus));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " dmem_req"}, 32'(bus.req), 32'd0);
    check({tag, " dmem_we"}, 32'(bus.we), 32'd0);
    check({tag, " dmem_addr"}, bus.addr, 32'd0);
    check({tag, " dmem_wdata"}, bus.wdata, 32'd0);
    check({tag, " mem_stall"}, 32'(mem_stall), 32'd0);
    check({tag, " WB_RegWrite"}, 32'(WB_RegWrite), 32'd0);
    check({tag, " WB_RegRd"}, 32'(WB_RegRd), 32'd0);
    check({tag, " WB_wd"}, WB_wd, 32'd0);
    check({tag, " misalign_err"}, 32'(misalign_err), 32'd0);
    check({tag, " bus_err"}, 32'(bus_err), 32'd0);
  endtask

  task automatic clear_inputs();
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_RegWrite = 1'b0; MEM_MemtoReg = 1'b0;
    MEM_ALUOut = '0; MEM_rd2 = '0; MEM_RegRd = '0; err_clr = 1'b0;
    bus.ack = 1'b0; bus.rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[11];
    obs_t got, exp_o;
    op_t  op;

    // Directed vectors; expectations are worked out by hand.
    tbl[0]  = '{mk_op(0,0,1,0,32'h1234,0,5,0,0,0),
                mk_exp(0,0,0,0,0,1,32'h1234,5,0,0)};
    tbl[1]  = '{mk_op(1,0,1,1,32'h100,0,7,3,32'hCAFE,0),
                mk_exp(4,4,0,32'h100,0,1,32'hCAFE,7,0,0)};
    tbl[2]  = '{mk_op(0,1,0,0,32'h104,32'hBEEF,0,0,0,0),
                mk_exp(1,1,1,32'h104,32'hBEEF,0,32'h104,0,0,0)};
    tbl[3]  = '{mk_op(1,0,1,0,32'h102,0,9,0,0,0),
                mk_exp(0,0,0,0,0,0,32'h102,9,1,0)};
    tbl[4]  = '{mk_op(0,0,1,0,32'h55,0,3,0,0,1),
                mk_exp(0,0,0,0,0,1,32'h55,3,0,0)};
    tbl[5]  = '{mk_op(1,0,1,0,32'h200,0,4,-1,0,0),
                mk_exp(16,16,0,32'h200,0,0,32'h200,4,0,1)};
    tbl[6]  = '{mk_op(0,0,0,0,0,0,0,0,0,1),
                mk_exp(0,0,0,0,0,0,0,0,0,0)};
    tbl[7]  = '{mk_op(1,1,1,1,32'h300,32'h77,12,1,32'h12345678,0),
                mk_exp(2,2,0,32'h300,32'h77,1,32'h12345678,12,0,0)};
    tbl[8]  = '{mk_op(0,1,0,0,32'h301,1,0,0,0,0),
                mk_exp(0,0,0,0,0,0,32'h301,0,1,0)};
    tbl[9]  = '{mk_op(1,0,1,0,32'h3,0,1,0,0,1),
                mk_exp(0,0,0,0,0,0,32'h3,1,1,0)};
    tbl[10] = '{mk_op(1,0,1,1,32'h400,0,2,0,32'hAA,0),
                mk_exp(1,1,0,32'h400,0,1,32'hAA,2,1,0)};

    // Reset values.
    reset = 1'b0;
    clear_inputs();
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, 1'b0, got);
      compare($sformatf("vec%0d", i), got, tbl[i].exp);
    end
    exp_mis = tbl[10].exp.mis;
    exp_bus = tbl[10].exp.bus;

    // Reset in the middle of an outstanding load, then a stray late ack.
    MEM_MemRead = 1'b1; MEM_RegWrite = 1'b1; MEM_ALUOut = 32'h500; MEM_RegRd = 5'd6;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    check("midwait dmem_req", 32'(bus.req), 32'd1);
    clear_inputs();
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    bus.ack = 1'b1;
    bus.rdata = 32'hDEAD;
    @(negedge clk);
    check("late_ack mem_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
    check("late_ack dmem_req", 32'(bus.req), 32'd0);
    check("late_ack WB_RegWrite", 32'(WB_RegWrite), 32'd0);
    exp_mis = 1'b0;
    exp_bus = 1'b0;
    op = mk_op(1,0,1,1,32'h600,0,8,0,32'h1111,0);
    exp_o = model(op, exp_mis, exp_bus);
    run_op(op, 1'b0, got);
    compare("post_reset", got, exp_o);
    exp_mis = exp_o.mis;
    exp_bus = exp_o.bus;

    // Randomized operations against the reference model.
    for (int n = 0; n < 200; n++) begin
      int kind;
      kind     = int'($urandom_range(0, 3));
      op.rd    = (kind == 1 || kind == 3);
      op.wr    = (kind == 2 || kind == 3);
      op.rw    = 1'($urandom_range(0, 1));
      op.m2r   = 1'($urandom_range(0, 1));
      op.alu   = $urandom;
      if ($urandom_range(0, 3) != 0) op.alu[1:0] = 2'b00;
      op.rd2   = $urandom;
      op.regrd = 5'($urandom_range(0, 31));
      op.delay = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 5));
      op.rdata = $urandom;
      op.clr   = ($urandom_range(0, 7) == 0);
      exp_o = model(op, exp_mis, exp_bus);
      run_op(op, 1'b1, got);
      compare($sformatf("rand%0d", n), got, exp_o);
      exp_mis = exp_o.mis;
      exp_bus = exp_o.bus;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
